// File: rtl/segre_mem_arbiter.sv
// segre_mem_arbiter: NUM_REQ-way main-memory arbiter, fixed priority with starvation promotion or round robin
module segre_mem_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 128,
  parameter int RR_MODE      = 0,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                          clk_i,
  input  logic                          rsn_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ-1:0]            req_we_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            rsp_valid_o,
  output logic [DATA_WIDTH-1:0]         rsp_data_o,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          busy_o,
  output logic                          mem_req_o,
  output logic                          mem_we_o,
  output logic [ADDR_WIDTH-1:0]         mem_addr_o,
  output logic [DATA_WIDTH-1:0]         mem_data_o,
  input  logic                          mem_rsp_valid_i,
  input  logic [DATA_WIDTH-1:0]         mem_rsp_data_i
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int CW = STARVE_LIMIT > 0 ? $clog2(STARVE_LIMIT + 1) : 1;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  state_t state, state_d;
  logic [IW-1:0] owner, win, idx, rr_ptr;
  logic [NUM_REQ-1:0] starved;
  logic [CW-1:0] wait_cnt [NUM_REQ];
  logic found;
  assign mem_req_o = state == REQ;
  assign busy_o = state != IDLE;
  assign rsp_valid_o = state == RESP ? NUM_REQ'(1) << owner : '0;
  always_comb begin
    starved = '0;
    for (int i = 0; i < NUM_REQ; i++)
      starved[i] = STARVE_LIMIT != 0 && wait_cnt[i] == CW'(STARVE_LIMIT);
  end
  always_comb begin
    win = '0;
    idx = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = RR_MODE != 0 ? IW'((int'(rr_ptr) + 1 + k) % NUM_REQ) : IW'(k);
      if (!found && req_valid_i[idx] && (RR_MODE != 0 || !(|(req_valid_i & starved)) || starved[idx])) begin
        win = idx;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    state_d = |req_valid_i ? REQ : IDLE;
      REQ:     state_d = WAIT;
      WAIT:    state_d = mem_rsp_valid_i ? RESP : WAIT;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      state <= IDLE;
      owner <= '0;
      grant_o <= '0;
      mem_we_o <= 1'b0;
      mem_addr_o <= '0;
      mem_data_o <= '0;
      rsp_data_o <= '0;
      rr_ptr <= IW'(NUM_REQ - 1);
    end else begin
      state <= state_d;
      if (state == IDLE && |req_valid_i) begin
        owner <= win;
        grant_o <= NUM_REQ'(1) << win;
        mem_we_o <= req_we_i[win];
        mem_addr_o <= req_addr_i[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
        mem_data_o <= req_data_i[int'(win)*DATA_WIDTH +: DATA_WIDTH];
        rr_ptr <= win;
      end
      if (state == RESP) grant_o <= '0;
      if (state == WAIT && mem_rsp_valid_i) rsp_data_o <= mem_rsp_data_i;
    end
  end
  always_ff @(posedge clk_i)
    for (int i = 0; i < NUM_REQ; i++)
      wait_cnt[i] <= (!rsn_i || !req_valid_i[i] || (state == IDLE && win == IW'(i))) ? '0 :
                     (state == IDLE && !starved[i] && STARVE_LIMIT != 0) ? wait_cnt[i] + CW'(1) : wait_cnt[i];
endmodule

// File: tb/tb_segre_mem_arbiter.sv
// tb_segre_mem_arbiter: scoreboard bench for fixed-priority and round-robin arbiter configurations
module tb_segre_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 128;
  typedef struct {int ch; logic we; logic [AW-1:0] addr; logic [DW-1:0] data;} exp_t;
  logic clk = 1'b0;
  logic rsn;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t fq[$];
  exp_t rq[$];
  logic [1:0] f_valid, f_we, f_rsp_valid, f_grant;
  logic [2*AW-1:0] f_addr;
  logic [2*DW-1:0] f_data;
  logic [DW-1:0] f_rsp_data, f_mdata, f_mrd;
  logic [AW-1:0] f_maddr;
  logic f_busy, f_mreq, f_mwe, f_mrv;
  logic [3:0] r_valid, r_we, r_rsp_valid, r_grant;
  logic [4*AW-1:0] r_addr;
  logic [4*DW-1:0] r_data;
  logic [DW-1:0] r_rsp_data, r_mdata, r_mrd;
  logic [AW-1:0] r_maddr;
  logic r_busy, r_mreq, r_mwe, r_mrv;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  segre_mem_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RR_MODE(0), .STARVE_LIMIT(2)) u_fix (
    .clk_i(clk), .rsn_i(rsn), .req_valid_i(f_valid), .req_we_i(f_we), .req_addr_i(f_addr), .req_data_i(f_data),
    .rsp_valid_o(f_rsp_valid), .rsp_data_o(f_rsp_data), .grant_o(f_grant), .busy_o(f_busy), .mem_req_o(f_mreq),
    .mem_we_o(f_mwe), .mem_addr_o(f_maddr), .mem_data_o(f_mdata), .mem_rsp_valid_i(f_mrv), .mem_rsp_data_i(f_mrd)
  );
  segre_mem_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RR_MODE(1), .STARVE_LIMIT(4)) u_rr (
    .clk_i(clk), .rsn_i(rsn), .req_valid_i(r_valid), .req_we_i(r_we), .req_addr_i(r_addr), .req_data_i(r_data),
    .rsp_valid_o(r_rsp_valid), .rsp_data_o(r_rsp_data), .grant_o(r_grant), .busy_o(r_busy), .mem_req_o(r_mreq),
    .mem_we_o(r_mwe), .mem_addr_o(r_maddr), .mem_data_o(r_mdata), .mem_rsp_valid_i(r_mrv), .mem_rsp_data_i(r_mrd)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic f_serve(input int lat, input logic [DW-1:0] rd, input bit glitch);
    exp_t e;
    logic [1:0] oh;
    checks++;
    if (f_busy !== 1'b0 || f_grant !== 2'b00) begin
      errors++;
      $display("FAIL f_idle busy=%b grant=%b expected 0/00", f_busy, f_grant);
    end
    tick();
    checks++;
    if (fq.size() == 0) begin
      errors++;
      $display("FAIL f_queue size=0 expected >0");
      return;
    end
    e = fq.pop_front();
    oh = 2'b01 << e.ch;
    for (int k = 0; k <= lat; k++) begin
      checks++;
      if (f_mreq !== (k == 0) || f_grant !== oh || f_busy !== 1'b1 || f_rsp_valid !== 2'b00 ||
          f_mwe !== e.we || f_maddr !== e.addr || f_mdata !== e.data) begin
        errors++;
        $display("FAIL f_txn k=%0d req=%b grant=%b busy=%b rsp=%b we=%b addr=%h data=%h expected req=%b grant=%b we=%b addr=%h data=%h",
                 k, f_mreq, f_grant, f_busy, f_rsp_valid, f_mwe, f_maddr, f_mdata, k == 0, oh, e.we, e.addr, e.data);
      end
      f_mrv = (k == lat) || (k == 0 && glitch);
      f_mrd = (k == lat) ? rd : ~rd;
      tick();
    end
    checks++;
    if (f_rsp_valid !== oh || f_rsp_data !== rd || f_grant !== oh || f_mreq !== 1'b0) begin
      errors++;
      $display("FAIL f_rsp rsp=%b data=%h grant=%b req=%b expected rsp=%b data=%h", f_rsp_valid, f_rsp_data, f_grant, f_mreq, oh, rd);
    end
    f_mrv = glitch;
    f_mrd = ~rd;
    f_valid[e.ch] = 1'b0;
    tick();
    checks++;
    if (f_rsp_valid !== 2'b00 || f_grant !== 2'b00 || f_busy !== 1'b0 || f_rsp_data !== rd) begin
      errors++;
      $display("FAIL f_release rsp=%b grant=%b busy=%b data=%h expected 00/00/0 data=%h", f_rsp_valid, f_grant, f_busy, f_rsp_data, rd);
    end
    f_mrv = 1'b0;
  endtask
  task automatic r_serve(input logic [DW-1:0] rd, output int t_req);
    exp_t e;
    logic [3:0] oh;
    tick();
    t_req = cyc;
    checks++;
    if (rq.size() == 0) begin
      errors++;
      $display("FAIL r_queue size=0 expected >0");
      return;
    end
    e = rq.pop_front();
    oh = 4'b0001 << e.ch;
    checks++;
    if (r_mreq !== 1'b1 || r_grant !== oh || r_maddr !== e.addr || r_mdata !== e.data || r_mwe !== e.we) begin
      errors++;
      $display("FAIL r_req req=%b grant=%b addr=%h expected req=1 grant=%b addr=%h", r_mreq, r_grant, r_maddr, oh, e.addr);
    end
    tick();
    r_mrv = 1'b1;
    r_mrd = rd;
    tick();
    checks++;
    if (r_rsp_valid !== oh || r_rsp_data !== rd) begin
      errors++;
      $display("FAIL r_rsp rsp=%b data=%h expected rsp=%b data=%h", r_rsp_valid, r_rsp_data, oh, rd);
    end
    r_mrv = 1'b0;
    r_valid[e.ch] = 1'b0;
    tick();
  endtask
  task automatic test_reset();
    rsn = 1'b0;
    {f_valid, f_we, f_addr, f_data, f_mrv, f_mrd} = '0;
    {r_valid, r_we, r_addr, r_data, r_mrv, r_mrd} = '0;
    repeat (3) tick();
    checks++;
    if ({f_grant, f_rsp_valid, f_busy, f_mreq, f_mwe} !== 7'd0 || f_maddr !== '0 || f_mdata !== '0 || f_rsp_data !== '0) begin
      errors++;
      $display("FAIL reset_fix grant=%b rsp=%b busy=%b req=%b we=%b addr=%h expected all 0", f_grant, f_rsp_valid, f_busy, f_mreq, f_mwe, f_maddr);
    end
    checks++;
    if ({r_grant, r_rsp_valid, r_busy, r_mreq, r_mwe} !== 11'd0 || r_maddr !== '0 || r_mdata !== '0 || r_rsp_data !== '0) begin
      errors++;
      $display("FAIL reset_rr grant=%b rsp=%b busy=%b req=%b we=%b addr=%h expected all 0", r_grant, r_rsp_valid, r_busy, r_mreq, r_mwe, r_maddr);
    end
    rsn = 1'b1;
    tick();
  endtask
  task automatic test_fixed_conflict();
    f_addr = {32'h0000_2000, 32'h0000_1000};
    f_data = {{4{32'h1111_1111}}, {4{32'h0000_0000}}};
    f_we = 2'b00;
    f_valid = 2'b11;
    fq.push_back('{0, 1'b0, 32'h0000_1000, {4{32'h0000_0000}}});
    fq.push_back('{1, 1'b0, 32'h0000_2000, {4{32'h1111_1111}}});
    f_serve(1, {4{32'hC0DE_0001}}, 1'b0);
    f_serve(1, {4{32'hC0DE_0002}}, 1'b0);
  endtask
  task automatic test_starvation();
    for (int r = 0; r < 2; r++) begin
      f_valid = 2'b11;
      fq.push_back('{0, 1'b0, 32'h0000_1000, {4{32'h0000_0000}}});
      fq.push_back('{0, 1'b0, 32'h0000_1000, {4{32'h0000_0000}}});
      fq.push_back('{1, 1'b0, 32'h0000_2000, {4{32'h1111_1111}}});
      f_serve(1, DW'(r * 3 + 1), 1'b0);
      f_valid[0] = 1'b1;
      f_serve(1, DW'(r * 3 + 2), 1'b0);
      f_valid[0] = 1'b1;
      f_serve(1, DW'(r * 3 + 3), 1'b0);
      fq.push_back('{0, 1'b0, 32'h0000_1000, {4{32'h0000_0000}}});
      f_serve(1, DW'(r * 3 + 9), 1'b0);
    end
  endtask
  task automatic test_write_path();
    f_we = 2'b10;
    f_addr[2*AW-1:AW] = 32'h0000_1040;
    f_data[2*DW-1:DW] = {16{8'hA5}};
    f_valid = 2'b10;
    fq.push_back('{1, 1'b1, 32'h0000_1040, {16{8'hA5}}});
    f_serve(5, {4{32'h5A5A_0F0F}}, 1'b0);
    f_we = 2'b00;
  endtask
  task automatic test_filtering();
    f_addr[AW-1:0] = 32'h0000_3300;
    f_data[DW-1:0] = {4{32'h7777_8888}};
    f_valid = 2'b01;
    fq.push_back('{0, 1'b0, 32'h0000_3300, {4{32'h7777_8888}}});
    f_serve(3, {4{32'hFEED_BEEF}}, 1'b1);
  endtask
  task automatic test_reset_mid_wait();
    f_we = 2'b01;
    f_addr[AW-1:0] = 32'hDEAD_0000;
    f_data[DW-1:0] = {4{32'h1234_5678}};
    f_valid = 2'b01;
    tick();
    f_mrv = 1'b0;
    tick();
    checks++;
    if (f_busy !== 1'b1 || f_mreq !== 1'b0 || f_grant !== 2'b01 || f_mwe !== 1'b1) begin
      errors++;
      $display("FAIL mid_wait busy=%b req=%b grant=%b we=%b expected 1/0/01/1", f_busy, f_mreq, f_grant, f_mwe);
    end
    rsn = 1'b0;
    f_valid = 2'b00;
    f_we = 2'b00;
    tick();
    checks++;
    if ({f_grant, f_rsp_valid, f_busy, f_mreq, f_mwe} !== 7'd0 || f_maddr !== '0 || f_mdata !== '0 || f_rsp_data !== '0) begin
      errors++;
      $display("FAIL mid_reset grant=%b rsp=%b busy=%b req=%b we=%b addr=%h data=%h expected all 0",
               f_grant, f_rsp_valid, f_busy, f_mreq, f_mwe, f_maddr, f_rsp_data);
    end
    rsn = 1'b1;
    f_mrv = 1'b1;
    f_mrd = '1;
    for (int k = 0; k < 2; k++) begin
      tick();
      f_mrv = 1'b0;
      checks++;
      if (f_rsp_valid !== 2'b00 || f_busy !== 1'b0 || f_rsp_data !== '0) begin
        errors++;
        $display("FAIL late_rsp k=%0d rsp=%b busy=%b data=%h expected 00/0/0", k, f_rsp_valid, f_busy, f_rsp_data);
      end
    end
  endtask
  task automatic test_rr_rotation();
    int t, t_prev;
    int order [5] = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 4; i++) begin
      r_addr[i*AW +: AW] = 32'h0000_4000 + 32'(i * 16);
      r_data[i*DW +: DW] = {4{32'(i + 100)}};
    end
    r_valid = 4'hF;
    for (int i = 0; i < 5; i++)
      rq.push_back('{order[i], 1'b0, 32'h0000_4000 + 32'(order[i] * 16), {4{32'(order[i] + 100)}}});
    t_prev = 0;
    for (int i = 0; i < 5; i++) begin
      r_serve(DW'(i + 50), t);
      if (i > 0) begin
        checks++;
        if (t - t_prev !== 4) begin
          errors++;
          $display("FAIL rr_spacing i=%0d gap=%0d expected 4", i, t - t_prev);
        end
      end
      t_prev = t;
      r_valid = 4'hF;
    end
    r_valid = 4'b1001;
    rq.push_back('{3, 1'b0, 32'h0000_4030, {4{32'd103}}});
    rq.push_back('{0, 1'b0, 32'h0000_4000, {4{32'd100}}});
    r_serve(DW'(77), t);
    r_serve(DW'(78), t);
    checks++;
    if (r_busy !== 1'b0 || r_grant !== 4'b0000) begin
      errors++;
      $display("FAIL rr_idle busy=%b grant=%b expected 0/0000", r_busy, r_grant);
    end
  endtask
  initial begin
    test_reset();
    test_fixed_conflict();
    test_starvation();
    test_write_path();
    test_filtering();
    test_reset_mid_wait();
    test_rr_rotation();
    checks++;
    if (fq.size() != 0 || rq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left fix=%0d rr=%0d expected 0/0", fq.size(), rq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog cycles=%0d expected completion", cyc);
    $fatal(1);
  end
endmodule
